ser_cmd_arbiter: RTL and testbench

- Shares the single serializer command channel between NUM_REQ independent requesters.
- Each requester submits an (object address, command) pair. The block holds one pending command per requester, arbitrates round-robin, range-checks the address, and drives the serializer's data/valid inputs.
- It tracks the serializer's busy handshake until the command has left, then reports per-requester completion, error or timeout.
- Sits directly upstream of the serializer in the object-control path.

---
 rtl/ser_cmd_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_ser_cmd_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ser_cmd_arbiter.sv
// ser_cmd_arbiter
//
// Shares one serializer command channel between NUM_REQ requesters. Each
// requester has a single-entry slot holding an (address, command) pair.
// Full slots are served round-robin. A command whose address is outside
// 1..NUM_OBJ is rejected without reaching the serializer. An accepted command
// is presented to the serializer for one cycle. The arbiter then follows the
// serializer's busy handshake and reports completion, rejection or a start
// timeout back to the owning requester.
//
// Ports
//   clk_i       clock; all state updates on posedge
//   rst_i       asynchronous reset, active low
//   req_val_i   per-requester command valid
//   req_addr_i  per-requester 5-bit object address, requester r at [5r+4:5r]
//   req_cmd_i   per-requester command bit
//   req_rdy_o   per-requester slot free
//   req_done_o  one-cycle pulse: command fully shifted out
//   req_err_o   one-cycle pulse: bad address or start timeout
//   busy_i      serializer busy
//   data_o      serializer command word {addr, cmd}
//   data_val_o  serializer command valid, one-cycle pulse
//   grant_o     index of the requester owning the channel
//   timeout_o   one-cycle pulse when busy_i fails to rise in time
module ser_cmd_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int NUM_OBJ       = 18,
    parameter int START_TIMEOUT = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_val_i,
    input  logic [5*NUM_REQ-1:0] req_addr_i,
    input  logic [NUM_REQ-1:0]   req_cmd_i,
    output logic [NUM_REQ-1:0]   req_rdy_o,
    output logic [NUM_REQ-1:0]   req_done_o,
    output logic [NUM_REQ-1:0]   req_err_o,
    input  logic                 busy_i,
    output logic [5:0]           data_o,
    output logic                 data_val_o,
    output logic [2:0]           grant_o,
    output logic                 timeout_o
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int IW1   = IDX_W + 1;
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [NUM_REQ-1:0] slot_full;
    logic [4:0]         slot_addr [NUM_REQ];
    logic [NUM_REQ-1:0] slot_cmd;

    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gnt;
    logic [CNT_W-1:0]   cnt;

    logic               sel_any;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W:0]     scan_idx;

    logic               do_grant;
    logic               do_reject;
    logic               do_free;
    logic               do_timeout;
    logic               do_done;

    function automatic logic addr_ok(input logic [4:0] a);
        return (a != 5'd0) && (a <= 5'(NUM_OBJ));
    endfunction

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
    endfunction

    assign req_rdy_o  = ~slot_full;
    assign data_val_o = (state == S_ISSUE);
    assign grant_o    = 3'(gnt);

    // First full slot at or after the pointer, wrapping around.
    always_comb begin
        sel_any  = 1'b0;
        sel_idx  = '0;
        scan_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = {1'b0, ptr} + IW1'(i);
            if (scan_idx >= IW1'(NUM_REQ)) begin
                scan_idx = scan_idx - IW1'(NUM_REQ);
            end
            if (!sel_any && slot_full[scan_idx[IDX_W-1:0]]) begin
                sel_any = 1'b1;
                sel_idx = scan_idx[IDX_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        do_grant   = 1'b0;
        do_reject  = 1'b0;
        do_free    = 1'b0;
        do_timeout = 1'b0;
        do_done    = 1'b0;
        case (state)
            S_IDLE: begin
                // A busy serializer here is still draining an earlier
                // transfer (e.g. one started before a reset), so hold off.
                if (!busy_i && sel_any) begin
                    do_grant = 1'b1;
                    if (addr_ok(slot_addr[sel_idx])) begin
                        state_nxt = S_ISSUE;
                    end else begin
                        do_reject = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                do_free   = 1'b1;
                state_nxt = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (busy_i) begin
                    state_nxt = S_WAIT_DONE;
                end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
                    // This is the START_TIMEOUT-th idle cycle.
                    do_timeout = 1'b1;
                    state_nxt  = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!busy_i) begin
                    do_done   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Grant bookkeeping, serializer word and status pulses.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr        <= '0;
            gnt        <= '0;
            cnt        <= '0;
            data_o     <= '0;
            req_done_o <= '0;
            req_err_o  <= '0;
            timeout_o  <= 1'b0;
        end else begin
            req_done_o <= '0;
            req_err_o  <= '0;
            timeout_o  <= 1'b0;
            if (do_grant) begin
                ptr <= wrap_inc(sel_idx);
                gnt <= sel_idx;
                if (do_reject) begin
                    req_err_o[sel_idx] <= 1'b1;
                end else begin
                    data_o <= {slot_addr[sel_idx], slot_cmd[sel_idx]};
                end
            end
            if (state == S_ISSUE) begin
                cnt <= '0;
            end else if (state == S_WAIT_START && !busy_i) begin
                cnt <= cnt + 1'b1;
            end
            if (do_timeout) begin
                timeout_o      <= 1'b1;
                req_err_o[gnt] <= 1'b1;
            end
            if (do_done) begin
                req_done_o[gnt] <= 1'b1;
            end
        end
    end

    // Slot occupancy. Accept and free never collide: a slot only frees
    // while full and only accepts while empty.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            slot_full <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if ((do_free && gnt == IDX_W'(r)) ||
                    (do_reject && sel_idx == IDX_W'(r))) begin
                    slot_full[r] <= 1'b0;
                end else if (req_val_i[r] && !slot_full[r]) begin
                    slot_full[r] <= 1'b1;
                end
            end
        end
    end

    // Slot payload is only meaningful while the slot is full.
    always_ff @(posedge clk_i) begin
        for (int r = 0; r < NUM_REQ; r++) begin
            if (req_val_i[r] && !slot_full[r]) begin
                slot_addr[r] <= req_addr_i[5*r +: 5];
                slot_cmd[r]  <= req_cmd_i[r];
            end
        end
    end

endmodule

// File: tb/tb_ser_cmd_arbiter.sv
module tb_ser_cmd_arbiter;

    localparam int NR = 4;

    logic          clk;
    logic          rst_i;
    logic [NR-1:0] req_val_i;
    logic [5*NR-1:0] req_addr_i;
    logic [NR-1:0] req_cmd_i;
    logic [NR-1:0] req_rdy_o;
    logic [NR-1:0] req_done_o;
    logic [NR-1:0] req_err_o;
    logic          busy_i;
    logic [5:0]    data_o;
    logic          data_val_o;
    logic [2:0]    grant_o;
    logic          timeout_o;

    ser_cmd_arbiter #(.NUM_REQ(4), .NUM_OBJ(18), .START_TIMEOUT(15)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_val_i  (req_val_i),
        .req_addr_i (req_addr_i),
        .req_cmd_i  (req_cmd_i),
        .req_rdy_o  (req_rdy_o),
        .req_done_o (req_done_o),
        .req_err_o  (req_err_o),
        .busy_i     (busy_i),
        .data_o     (data_o),
        .data_val_o (data_val_o),
        .grant_o    (grant_o),
        .timeout_o  (timeout_o)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [8:0]    exp_issue [$];
    logic [NR-1:0] exp_err   [$];
    logic [NR-1:0] exp_done  [$];
    int            exp_to = 0;

    int last_acc        = 0;
    int last_issue_cyc  = 0;
    int busy_fall_cyc   = 0;
    int issue_seen      = 0;
    int done_seen       = 0;
    int issue_done_snap = 0;

    logic auto_en    = 1'b1;
    logic force_busy = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serializer model: busy rises the cycle after data_val_o and stays
    // high for 7 cycles; force_busy holds it high regardless.
    initial begin
        logic pend;
        int   left;
        pend   = 1'b0;
        left   = 0;
        busy_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (pend) begin
                left = 7;
                pend = 1'b0;
            end else if (left > 0) begin
                left--;
            end
            if (auto_en && data_val_o) pend = 1'b1;
            busy_i = force_busy || (left > 0);
        end
    end

    // Monitor / scoreboard.
    initial begin
        logic prev_busy;
        logic prev_val;
        logic [8:0]    ei;
        logic [NR-1:0] ev;
        prev_busy = 1'b0;
        prev_val  = 1'b0;
        forever begin
            @(negedge clk);
            if (data_val_o) begin
                chk("val_pulse_width", 32'(prev_val), 32'd0);
                if (exp_issue.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL issue_unexpected: got grant=%0d data=%b expected none", grant_o, data_o);
                end else begin
                    ei = exp_issue.pop_front();
                    chk("issue_grant_data", 32'({grant_o, data_o}), 32'(ei));
                end
                issue_seen++;
                last_issue_cyc  = cyc;
                issue_done_snap = done_seen;
            end
            if (req_err_o != '0) begin
                if (exp_err.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL err_unexpected: got %b expected none", req_err_o);
                end else begin
                    ev = exp_err.pop_front();
                    chk("err_vec", 32'(req_err_o), 32'(ev));
                end
            end
            if (req_done_o != '0) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL done_unexpected: got %b expected none", req_done_o);
                end else begin
                    ev = exp_done.pop_front();
                    chk("done_vec", 32'(req_done_o), 32'(ev));
                end
                chk("done_after_busy_fall", 32'(cyc), 32'(busy_fall_cyc + 1));
                done_seen++;
            end
            if (timeout_o) begin
                checks++;
                if (exp_to == 0) begin
                    failures++;
                    $display("FAIL timeout_unexpected: got 1 expected 0");
                end else begin
                    exp_to--;
                end
                chk("timeout_latency", 32'(cyc), 32'(last_issue_cyc + 16));
                chk("timeout_with_err", 32'(req_err_o != '0), 32'd1);
            end
            if (!busy_i && prev_busy) busy_fall_cyc = cyc;
            prev_busy = busy_i;
            prev_val  = data_val_o;
        end
    end

    task automatic post_multi(input logic [NR-1:0] m, input logic [5*NR-1:0] a, input logic [NR-1:0] c);
        @(negedge clk);
        req_val_i  = m;
        req_addr_i = a;
        req_cmd_i  = c;
        @(posedge clk);
        #1;
        last_acc = cyc;
        @(negedge clk);
        req_val_i = '0;
    endtask

    task automatic post(input int r, input logic [4:0] a, input logic c);
        logic [NR-1:0]   m;
        logic [5*NR-1:0] av;
        logic [NR-1:0]   cv;
        m  = '0;
        av = '0;
        cv = '0;
        m[r]         = 1'b1;
        av[5*r +: 5] = a;
        cv[r]        = c;
        post_multi(m, av, cv);
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        while ((exp_issue.size() != 0 || exp_err.size() != 0 || exp_done.size() != 0 ||
                exp_to != 0 || req_rdy_o != '1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_quiet_budget", 32'(n < budget), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_busy(input int budget);
        int n;
        n = 0;
        while (!busy_i && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("wait_busy_budget", 32'(n < budget), 32'd1);
    endtask

    initial begin
        int t1_acc;
        int d0;
        int iss0;
        rst_i      = 1'b0;
        req_val_i  = '0;
        req_addr_i = '0;
        req_cmd_i  = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_rdy", 32'(req_rdy_o), 32'hF);
        chk("rst_done", 32'(req_done_o), 32'd0);
        chk("rst_err", 32'(req_err_o), 32'd0);
        chk("rst_val", 32'(data_val_o), 32'd0);
        chk("rst_timeout", 32'(timeout_o), 32'd0);
        chk("rst_data", 32'(data_o), 32'd0);
        chk("rst_grant", 32'(grant_o), 32'd0);
        rst_i = 1'b1;

        // Single request: addr 5, cmd 1
        exp_issue.push_back({3'd0, 6'b001011});
        exp_done.push_back(4'b0001);
        post(0, 5'd5, 1'b1);
        t1_acc = last_acc;
        wait_quiet(100);
        chk("issue_latency", 32'(last_issue_cyc), 32'(t1_acc + 1));
        chk("t1_rdy0", 32'(req_rdy_o[0]), 32'd1);

        // Round robin from pointer 0: 0,1,2,3
        @(negedge clk);
        rst_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        exp_issue.push_back({3'd0, 6'b000010});
        exp_issue.push_back({3'd1, 6'b000101});
        exp_issue.push_back({3'd2, 6'b100010});
        exp_issue.push_back({3'd3, 6'b100101});
        exp_done.push_back(4'b0001);
        exp_done.push_back(4'b0010);
        exp_done.push_back(4'b0100);
        exp_done.push_back(4'b1000);
        post_multi(4'b1111, {5'd18, 5'd17, 5'd2, 5'd1}, 4'b1010);
        wait_quiet(300);
        // Move pointer to 1, then r0+r2 together: 2 before 0
        exp_issue.push_back({3'd0, 6'b000111});
        exp_done.push_back(4'b0001);
        post(0, 5'd3, 1'b1);
        wait_quiet(100);
        exp_issue.push_back({3'd2, 6'b001101});
        exp_issue.push_back({3'd0, 6'b001000});
        exp_done.push_back(4'b0100);
        exp_done.push_back(4'b0001);
        post_multi(4'b0101, {5'd0, 5'd6, 5'd0, 5'd4}, 4'b0100);
        wait_quiet(200);

        // Address range: 0 and 19 rejected, 18 issued
        exp_err.push_back(4'b0010);
        post(1, 5'd0, 1'b0);
        wait_quiet(50);
        exp_err.push_back(4'b0010);
        post(1, 5'd19, 1'b1);
        wait_quiet(50);
        exp_issue.push_back({3'd1, 6'b100100});
        exp_done.push_back(4'b0010);
        post(1, 5'd18, 1'b0);
        wait_quiet(100);

        // Start timeout with busy held low; pending r2 granted next
        auto_en = 1'b0;
        exp_issue.push_back({3'd3, 6'b001110});
        exp_err.push_back(4'b1000);
        exp_issue.push_back({3'd2, 6'b000111});
        exp_err.push_back(4'b0100);
        exp_to = 2;
        post(3, 5'd7, 1'b0);
        post(2, 5'd3, 1'b1);
        wait_quiet(200);
        auto_en = 1'b1;

        // Backpressure on r0
        d0 = done_seen;
        exp_issue.push_back({3'd0, 6'b010010});
        exp_done.push_back(4'b0001);
        exp_issue.push_back({3'd0, 6'b010101});
        exp_done.push_back(4'b0001);
        post(0, 5'd9, 1'b0);
        wait_busy(50);
        chk("bp_rdy_after_issue", 32'(req_rdy_o[0]), 32'd1);
        post(0, 5'd10, 1'b1);
        chk("bp_rdy_full", 32'(req_rdy_o[0]), 32'd0);
        post(0, 5'd11, 1'b0);
        chk("bp_rdy_still_full", 32'(req_rdy_o[0]), 32'd0);
        wait_quiet(150);
        chk("bp_issue_after_done", 32'(issue_done_snap), 32'(d0 + 1));

        // Reset mid-operation during WAIT_DONE
        exp_issue.push_back({3'd1, 6'b001001});
        post(1, 5'd4, 1'b1);
        wait_busy(50);
        force_busy = 1'b1;
        post(2, 5'd5, 1'b0);
        chk("pre_rst_rdy", 32'(req_rdy_o), 32'b1011);
        @(negedge clk);
        #2;
        rst_i = 1'b0;
        #1;
        chk("mid_rst_rdy", 32'(req_rdy_o), 32'hF);
        chk("mid_rst_data", 32'(data_o), 32'd0);
        chk("mid_rst_grant", 32'(grant_o), 32'd0);
        chk("mid_rst_val", 32'(data_val_o), 32'd0);
        chk("mid_rst_pulses", 32'({req_done_o, req_err_o, timeout_o}), 32'd0);
        @(negedge clk);
        rst_i = 1'b1;
        iss0 = issue_seen;
        post(3, 5'd2, 1'b1);
        repeat (6) @(negedge clk);
        chk("no_grant_while_busy", 32'(issue_seen), 32'(iss0));
        chk("post_rst_rdy", 32'(req_rdy_o), 32'b0111);
        exp_issue.push_back({3'd3, 6'b000101});
        exp_done.push_back(4'b1000);
        force_busy = 1'b0;
        wait_quiet(100);

        chk("scoreboard_empty",
            32'(exp_issue.size() + exp_err.size() + exp_done.size() + exp_to), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
